// File: rtl/nfu_2_adder_tree.sv
// ---------------------------------------------------------------------------
// nfu_2_adder_tree
//   NFU-2 stage. Reduces the Tn x Tn product matrix from nfu_1 to Tn neuron
//   sums with one pipelined saturating adder tree per neuron. A partial-sum
//   accumulator then folds successive input tiles of a neuron group together.
//   It is seeded from i_init_sums on the first tile and publishes the group
//   sums on the last tile.
//
//   Handshake: valid-only, with no backpressure. Every cycle with i_valid=1
//   is an accepted beat. i_first and i_last mean something only on such a
//   beat. o_valid is a one-cycle pulse, and o_sums holds its value until the
//   next pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_valid      product beat valid
//   i_first      beat is the first tile of a neuron group
//   i_last       beat is the last tile of a neuron group
//   i_products   Tn*Tn products; element [i*Tn+j] feeds neuron j
//   i_init_sums  Tn seed sums, sampled with i_first
//   o_valid      one-cycle pulse: o_sums holds final group sums
//   o_sums       neuron j at [(j+1)*BIT_WIDTH-1 : j*BIT_WIDTH]
//   o_seq_err    sticky first/last sequencing error flag
// ---------------------------------------------------------------------------
module nfu_2_adder_tree #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int TnxTn     = 256,
    parameter int LOG2TN    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic                       i_first,
    input  logic                       i_last,
    input  logic [BIT_WIDTH*TnxTn-1:0] i_products,
    input  logic [BIT_WIDTH*Tn-1:0]    i_init_sums,
    output logic                       o_valid,
    output logic [BIT_WIDTH*Tn-1:0]    o_sums,
    output logic                       o_seq_err
);

    localparam int MSB = BIT_WIDTH - 1;

    // Two's-complement add that clamps instead of wrapping. Overflow can only
    // happen when both operands have the same sign and the sum's sign flips.
    function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                     input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH-1:0] s;
        s = a + b;
        if ((a[MSB] == b[MSB]) && (s[MSB] != a[MSB]))
            sat_add = a[MSB] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                             : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        else
            sat_add = s;
    endfunction

    // -----------------------------------------------------------------------
    // Control pipeline. Stage s runs alongside tree level s. Stage 0 is the
    // registered input beat, and stage LOG2TN lines up with the tree output.
    // -----------------------------------------------------------------------
    logic [LOG2TN:0]         vld_q;
    logic [LOG2TN:0]         first_q;
    logic [LOG2TN:0]         last_q;
    logic [BIT_WIDTH*Tn-1:0] init_q [LOG2TN+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q   <= {vld_q[LOG2TN-1:0], i_valid};
            first_q <= {first_q[LOG2TN-1:0], i_first};
            last_q  <= {last_q[LOG2TN-1:0], i_last};
        end
    end

    // Seed sums only move with a valid beat, so gaps leave them untouched.
    always_ff @(posedge clk) begin
        if (i_valid) init_q[0] <= i_init_sums;
        for (int s = 1; s <= LOG2TN; s++) begin
            if (vld_q[s-1]) init_q[s] <= init_q[s-1];
        end
    end

    // -----------------------------------------------------------------------
    // Adder trees. Level 0 holds the registered products, rearranged so that
    // node_q[j][i] is product i of neuron j. Level l holds Tn>>l nodes per
    // neuron. Node k of level l is the sum of nodes (2k, 2k+1) of level l-1.
    // Each level loads only when a valid beat is moving into it.
    // -----------------------------------------------------------------------
    for (genvar l = 0; l <= LOG2TN; l++) begin : g_lvl
        localparam int NODES = Tn >> l;
        logic [BIT_WIDTH-1:0] node_q [Tn][NODES];

        if (l == 0) begin : g_in
            always_ff @(posedge clk) begin
                if (i_valid) begin
                    for (int j = 0; j < Tn; j++) begin
                        for (int i = 0; i < Tn; i++) begin
                            node_q[j][i] <= i_products[(i*Tn+j)*BIT_WIDTH +: BIT_WIDTH];
                        end
                    end
                end
            end
        end else begin : g_add
            always_ff @(posedge clk) begin
                if (vld_q[l-1]) begin
                    for (int j = 0; j < Tn; j++) begin
                        for (int k = 0; k < NODES; k++) begin
                            node_q[j][k] <= sat_add(g_lvl[l-1].node_q[j][2*k],
                                                    g_lvl[l-1].node_q[j][2*k+1]);
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator FSM, driven by the beat that leaves the tree.
    // -----------------------------------------------------------------------
    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    state_t                  state_q, state_d;
    logic [BIT_WIDTH-1:0]    acc_q [Tn];
    logic [BIT_WIDTH-1:0]    acc_d [Tn];
    logic [BIT_WIDTH*Tn-1:0] sums_q;
    logic                    valid_q;
    logic                    seq_err_q;
    logic                    beat;
    logic                    beat_first;
    logic                    beat_last;
    logic                    seq_err_hit;

    assign beat       = vld_q[LOG2TN];
    assign beat_first = first_q[LOG2TN];
    assign beat_last  = last_q[LOG2TN];

    // Two things count as sequencing errors. One is a group that starts
    // without i_first; it is then treated as a first tile with a zero seed.
    // The other is an i_first that arrives while a group is still open; that
    // group is dropped and the new one starts from its own seed.
    assign seq_err_hit = beat && (((state_q == ST_IDLE) && !beat_first) ||
                                  ((state_q == ST_ACCUM) && beat_first));

    always_comb begin
        state_d = beat_last ? ST_IDLE : ST_ACCUM;
        for (int j = 0; j < Tn; j++) begin
            acc_d[j] = sat_add(beat_first ? init_q[LOG2TN][j*BIT_WIDTH +: BIT_WIDTH]
                                          : ((state_q == ST_ACCUM) ? acc_q[j] : '0),
                               g_lvl[LOG2TN].node_q[j][0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            sums_q    <= '0;
            seq_err_q <= 1'b0;
            for (int j = 0; j < Tn; j++) acc_q[j] <= '0;
        end else begin
            valid_q <= 1'b0;
            if (beat) begin
                state_q <= state_d;
                for (int j = 0; j < Tn; j++) acc_q[j] <= acc_d[j];
                if (beat_last) begin
                    for (int j = 0; j < Tn; j++) sums_q[j*BIT_WIDTH +: BIT_WIDTH] <= acc_d[j];
                    valid_q <= 1'b1;
                end
            end
            if (seq_err_hit) seq_err_q <= 1'b1;
        end
    end

    assign o_valid   = valid_q;
    assign o_sums    = sums_q;
    assign o_seq_err = seq_err_q;

endmodule

// File: tb/tb_nfu_2_adder_tree.sv
module tb_nfu_2_adder_tree;

    localparam int BW = 16;
    localparam int TN = 16;
    localparam int NP = TN * TN;
    localparam int PW = BW * NP;
    localparam int SW = BW * TN;
    localparam int LAT = 6;  // drive negedge -> sampling edge t -> o_valid seen after edge t+5

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_first;
    logic          i_last;
    logic [PW-1:0] i_products;
    logic [SW-1:0] i_init_sums;
    logic          o_valid;
    logic [SW-1:0] o_sums;
    logic          o_seq_err;

    nfu_2_adder_tree #(
        .BIT_WIDTH(BW), .Tn(TN), .TnxTn(NP), .LOG2TN(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_first     (i_first),
        .i_last      (i_last),
        .i_products  (i_products),
        .i_init_sums (i_init_sums),
        .o_valid     (o_valid),
        .o_sums      (o_sums),
        .o_seq_err   (o_seq_err)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int            tests = 0;
    int            fails = 0;
    logic [SW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_o_valid", SW'(1), SW'(0));
            end else begin
                logic [SW-1:0] e;
                int            c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("o_sums", o_sums, e);
                check("o_valid_cycle", SW'(cyc), SW'(c));
            end
        end
    end

    // ---------------- reference model ----------------
    int            m_state;  // 0 idle, 1 accumulating
    logic [BW-1:0] m_acc [TN];
    logic          m_err;

    function automatic logic [BW-1:0] m_sat(input logic [BW-1:0] a, input logic [BW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[BW-1:0];
    endfunction

    function automatic logic [BW-1:0] m_tree(input logic [PW-1:0] p, input int j);
        logic [BW-1:0] v [TN];
        for (int i = 0; i < TN; i++) v[i] = p[(i*TN+j)*BW +: BW];
        for (int n = TN / 2; n >= 1; n = n / 2)
            for (int k = 0; k < n; k++) v[k] = m_sat(v[2*k], v[2*k+1]);
        return v[0];
    endfunction

    function automatic logic [PW-1:0] fill(input logic [BW-1:0] v);
        logic [PW-1:0] r;
        for (int i = 0; i < NP; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [SW-1:0] splat(input logic [BW-1:0] v);
        logic [SW-1:0] r;
        for (int i = 0; i < TN; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic beat(input logic f, input logic l, input logic [PW-1:0] p, input logic [SW-1:0] ini);
        logic [SW-1:0] e;
        logic [BW-1:0] seed;
        @(negedge clk);
        i_valid = 1'b1; i_first = f; i_last = l; i_products = p; i_init_sums = ini;
        if ((m_state == 0 && !f) || (m_state == 1 && f)) m_err = 1'b1;
        for (int j = 0; j < TN; j++) begin
            seed = f ? ini[j*BW +: BW] : ((m_state == 1) ? m_acc[j] : '0);
            m_acc[j] = m_sat(seed, m_tree(p, j));
            e[j*BW +: BW] = m_acc[j];
        end
        if (l) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc + LAT);
            m_state = 0;
        end else begin
            m_state = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_state = 0;
        m_err = 1'b0;
        for (int j = 0; j < TN; j++) m_acc[j] = '0;
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending_results", SW'(exp_q.size()), SW'(0));
        idle(3);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [PW-1:0] p;
        rst = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
        i_products = '0; i_init_sums = '0;
        m_state = 0; m_err = 1'b0;
        for (int j = 0; j < TN; j++) m_acc[j] = '0;

        repeat (3) @(negedge clk);
        check("reset_o_valid", SW'(o_valid), SW'(0));
        check("reset_o_sums", o_sums, SW'(0));
        check("reset_o_seq_err", SW'(o_seq_err), SW'(0));
        rst = 1'b0;

        // single tile, all products 0x0400
        beat(1, 1, fill(16'h0400), '0);
        drain();

        // lane mapping: only neuron 5 gets products
        p = '0;
        for (int i = 0; i < TN; i++) p[(i*TN+5)*BW +: BW] = 16'h0400;
        beat(1, 1, p, '0);
        drain();

        // three back-to-back tiles
        beat(1, 0, fill(16'h0100), splat(16'h0400));
        beat(0, 0, fill(16'h0100), splat(16'h0400));
        beat(0, 1, fill(16'h0100), splat(16'h0400));
        drain();

        // same group with 2-cycle gaps
        beat(1, 0, fill(16'h0100), splat(16'h0400));
        idle(2);
        beat(0, 0, fill(16'h0100), splat(16'h0400));
        idle(2);
        beat(0, 1, fill(16'h0100), splat(16'h0400));
        drain();

        // saturation in the tree, both directions
        beat(1, 1, fill(16'h7000), '0);
        drain();
        beat(1, 1, fill(16'h9000), '0);
        drain();
        // saturated accumulator plus 0x0400 stays at 0x7FFF
        beat(1, 0, fill(16'h7000), '0);
        beat(0, 1, fill(16'h0040), '0);
        drain();
        check("seq_err_clean", SW'(o_seq_err), SW'(m_err));

        // random well-formed groups with random gaps
        for (int g = 0; g < 4; g++) begin
            int ntiles;
            logic [SW-1:0] ini;
            ntiles = $urandom_range(1, 3);
            for (int w = 0; w < SW / 32; w++) ini[w*32 +: 32] = $urandom;
            for (int t = 0; t < ntiles; t++) begin
                for (int w = 0; w < PW / 32; w++) p[w*32 +: 32] = $urandom;
                beat(t == 0, t == ntiles - 1, p, ini);
                idle($urandom_range(0, 2));
            end
        end
        drain();
        check("seq_err_after_random", SW'(o_seq_err), SW'(m_err));

        // group started without i_first: init ignored, sticky error
        beat(0, 1, fill(16'h0400), splat(16'h1000));
        drain();
        check("seq_err_set", SW'(o_seq_err), SW'(m_err));
        idle(5);
        check("seq_err_sticky", SW'(o_seq_err), SW'(1));

        // reset after 2 of 3 tiles, then a fresh single tile
        beat(1, 0, fill(16'h0400), '0);
        beat(0, 0, fill(16'h0400), '0);
        do_reset();
        idle(12);
        check("seq_err_after_reset", SW'(o_seq_err), SW'(0));
        beat(1, 1, fill(16'h0400), '0);
        drain();
        check("seq_err_post_reset_tile", SW'(o_seq_err), SW'(m_err));

        idle(5);
        check("scoreboard_empty", SW'(exp_q.size()), SW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
